// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: opcodes, register map, status bits and FSM states for the SPI memory command decoder
package spi_mem_pkg;
  localparam logic [7:0] CMD_REG_RD = 8'h80;
  localparam logic [7:0] CMD_MEM    = 8'hC0;
  localparam logic [7:0] CMD_BURST  = 8'hD0;
  localparam logic [7:0] CMD_MIX    = 8'h90;
  localparam logic [7:0] REG_ID      = 8'd0;
  localparam logic [7:0] REG_STATUS  = 8'd1;
  localparam logic [7:0] REG_ADDR_LO = 8'd2;
  localparam logic [7:0] REG_ADDR_HI = 8'd3;
  localparam logic [7:0] REG_RDATA   = 8'd4;
  localparam logic [7:0] REG_MIX_HI  = 8'd5;
  localparam int ST_UNDERRUN = 0;
  localparam int ST_WDROP    = 1;
  localparam int ST_BUSY     = 2;
  typedef enum logic [3:0] {
    S_IDLE, S_REG, S_MEM_ALO, S_MEM_AHI, S_MEM_WDATA, S_MEM_DUMMY,
    S_BST_LEN, S_BST_ALO, S_BST_AHI, S_BST_DUMMY, S_BST_DATA,
    S_MIX_ADDR, S_MIX_DLO, S_MIX_DHI, S_MIX_DUMMY
  } state_t;
  // Opcode family match: bit 8 selects read/write, low byte must be zero
  function automatic logic is_op(input logic [15:0] w, input logic [7:0] op);
    return w[15:9] == op[7:1] && w[7:0] == 8'h00;
  endfunction
endpackage

// File: rtl/spi_mem_req_arb.sv
// spi_mem_req_arb: one-deep pending request slot turning requests plus busy into one-cycle enables
module spi_mem_req_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              free,
  output logic              wr_enable,
  output logic              rd_enable,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] wr_data
);
  logic pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d, fire, accept;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_wr_q <= 1'b0;
      pend_rd_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      pend_wr_q <= pend_wr_d;
      pend_rd_q <= pend_rd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // The slot frees in the same cycle it fires, so back-to-back requests are accepted
  always_comb begin
    fire      = (pend_wr_q | pend_rd_q) & ~busy;
    free      = ~(pend_wr_q | pend_rd_q) | fire;
    accept    = (wr_req | rd_req) & free;
    pend_wr_d = accept ? wr_req : pend_wr_q & ~fire;
    pend_rd_d = accept ? rd_req : pend_rd_q & ~fire;
    addr_d    = accept ? req_addr : addr_q;
    data_d    = accept ? req_data : data_q;
    wr_enable = pend_wr_q & ~busy;
    rd_enable = pend_rd_q & ~busy;
    wr_addr   = addr_q;
    rd_addr   = addr_q;
    wr_data   = data_q;
  end
endmodule

// File: rtl/spi_mem_cmd_decoder.sv
// spi_mem_cmd_decoder: SPI word command parser driving SDRAM read/write requests
// Optional mix-port command group enabled by defining SPI_MEM_MIX_EN.
module spi_mem_cmd_decoder
  import spi_mem_pkg::*;
#(
  parameter logic [15:0] ID_VALUE = 16'hC45A,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_word,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_word,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_enable,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  input  logic              busy,
`ifdef SPI_MEM_MIX_EN
  output logic [7:0]        mix_addr,
  output logic [31:0]       mix_wdata,
  output logic              mix_we,
  output logic              mix_re,
  input  logic [31:0]       mix_rdata,
`endif
  output logic              cmd_active
);
  state_t state_q, state_d;
  logic [DATA_W-1:0] tx_word_q, tx_word_d, len_q, len_d, reg4_q, reg4_d;
  logic [DATA_W-1:0] req_data, reg_val, status, mix_hi;
  logic [ADDR_W-1:0] addr_q, addr_d, req_addr, ahi_addr;
  logic is_wr_q, is_wr_d, rd_wait_q, rd_wait_d, underrun_q, underrun_d, wdrop_q, wdrop_d;
  logic wr_req, rd_req, arb_free, rd_late, bst_rd, mix_cmd;
`ifdef SPI_MEM_MIX_EN
  logic [7:0] mix_addr_q, mix_addr_d;
  logic [31:0] mix_wdata_q, mix_wdata_d;
  logic mix_we_q, mix_we_d, mix_re_q, mix_re_d;
  logic [15:0] reg5_q, reg5_d;
  assign mix_cmd = is_op(rx_word, CMD_MIX);
  assign mix_hi  = reg5_q;
`else
  assign mix_cmd = 1'b0;
  assign mix_hi  = '0;
`endif

  spi_mem_req_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_arb (
    .clk(clk), .rst(rst), .busy(busy), .wr_req(wr_req), .rd_req(rd_req),
    .req_addr(req_addr), .req_data(req_data), .free(arb_free),
    .wr_enable(wr_enable), .rd_enable(rd_enable),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_word_q  <= '0;
      len_q      <= '0;
      reg4_q     <= '0;
      addr_q     <= '0;
      is_wr_q    <= 1'b0;
      rd_wait_q  <= 1'b0;
      underrun_q <= 1'b0;
      wdrop_q    <= 1'b0;
`ifdef SPI_MEM_MIX_EN
      mix_addr_q  <= '0;
      mix_wdata_q <= '0;
      mix_we_q    <= 1'b0;
      mix_re_q    <= 1'b0;
      reg5_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tx_word_q  <= tx_word_d;
      len_q      <= len_d;
      reg4_q     <= reg4_d;
      addr_q     <= addr_d;
      is_wr_q    <= is_wr_d;
      rd_wait_q  <= rd_wait_d;
      underrun_q <= underrun_d;
      wdrop_q    <= wdrop_d;
`ifdef SPI_MEM_MIX_EN
      mix_addr_q  <= mix_addr_d;
      mix_wdata_q <= mix_wdata_d;
      mix_we_q    <= mix_we_d;
      mix_re_q    <= mix_re_d;
      reg5_q      <= reg5_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx_valid)
      case (state_q)
        S_IDLE:      state_d = rx_word[15:8] == CMD_REG_RD ? S_REG :
                               is_op(rx_word, CMD_MEM) ? S_MEM_ALO :
                               is_op(rx_word, CMD_BURST) ? S_BST_LEN :
                               mix_cmd ? S_MIX_ADDR : S_IDLE;
        S_MEM_ALO:   state_d = S_MEM_AHI;
        S_MEM_AHI:   state_d = is_wr_q ? S_MEM_WDATA : S_MEM_DUMMY;
        S_BST_LEN:   state_d = S_BST_ALO;
        S_BST_ALO:   state_d = S_BST_AHI;
        S_BST_AHI:   state_d = !is_wr_q ? S_BST_DUMMY : len_q == '0 ? S_IDLE : S_BST_DATA;
        S_BST_DUMMY: state_d = len_q == '0 ? S_IDLE : S_BST_DATA;
        S_BST_DATA:  state_d = len_q == 16'd1 ? S_IDLE : S_BST_DATA;
        S_MIX_ADDR:  state_d = is_wr_q ? S_MIX_DLO : S_MIX_DUMMY;
        S_MIX_DLO:   state_d = S_MIX_DHI;
        default:     state_d = S_IDLE;
      endcase
  end

  always_comb begin
    status = '0;
    status[ST_UNDERRUN] = underrun_q;
    status[ST_WDROP] = wdrop_q;
    status[ST_BUSY] = busy;
    status[7:4] = state_q;
    reg_val = rx_word[7:0] == REG_ID ? ID_VALUE :
              rx_word[7:0] == REG_STATUS ? status :
              rx_word[7:0] == REG_ADDR_LO ? addr_q[15:0] :
              rx_word[7:0] == REG_ADDR_HI ? addr_q[31:16] :
              rx_word[7:0] == REG_RDATA ? reg4_q :
              rx_word[7:0] == REG_MIX_HI ? mix_hi : '0;
  end

  // addr_q always holds the next address to issue in a burst
  always_comb begin
    tx_word_d  = tx_word_q;
    len_d      = len_q;
    reg4_d     = reg4_q;
    addr_d     = addr_q;
    is_wr_d    = is_wr_q;
    underrun_d = underrun_q;
    wdrop_d    = wdrop_q;
    rd_late    = rd_wait_q & ~rd_ready;
    rd_wait_d  = rd_late;
    bst_rd     = !is_wr_q && (state_q == S_BST_DUMMY || state_q == S_BST_DATA);
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    req_addr   = addr_q;
    req_data   = rx_word;
    ahi_addr   = {rx_word, addr_q[15:0]};
`ifdef SPI_MEM_MIX_EN
    mix_addr_d  = mix_addr_q;
    mix_wdata_d = mix_wdata_q;
    mix_we_d    = 1'b0;
    mix_re_d    = 1'b0;
    reg5_d      = reg5_q;
    if (mix_re_q) begin
      reg4_d = mix_rdata[15:0];
      reg5_d = mix_rdata[31:16];
    end
`endif
    if (rd_ready) begin
      if (bst_rd) tx_word_d = rd_data;
      else reg4_d = rd_data;
    end
    if (rx_valid)
      case (state_q)
        S_IDLE: begin
          is_wr_d = rx_word[8];
          if (rx_word[15:8] == CMD_REG_RD) begin
            tx_word_d = reg_val;
            if (rx_word[7:0] == REG_STATUS) {wdrop_d, underrun_d} = 2'b00;
          end
        end
        S_MEM_ALO, S_BST_ALO: addr_d[15:0] = rx_word;
        S_MEM_AHI: begin
          addr_d   = ahi_addr;
          rd_req   = !is_wr_q;
          req_addr = ahi_addr;
        end
        S_MEM_WDATA: wr_req = 1'b1;
        S_BST_LEN:   len_d = rx_word;
        S_BST_AHI: begin
          rd_req   = !is_wr_q && len_q != '0;
          req_addr = ahi_addr;
          addr_d   = rd_req ? ahi_addr + ADDR_W'(1) : ahi_addr;
        end
        S_BST_DUMMY: underrun_d = underrun_q | rd_late;
        S_BST_DATA: begin
          len_d = len_q - 16'd1;
          wr_req = is_wr_q;
          rd_req = !is_wr_q && len_q != 16'd1;
          underrun_d = underrun_q | (!is_wr_q & rd_late);
          addr_d = (wr_req || rd_req) ? addr_q + ADDR_W'(1) : addr_q;
        end
`ifdef SPI_MEM_MIX_EN
        S_MIX_ADDR: begin
          mix_addr_d = rx_word[7:0];
          mix_re_d   = !is_wr_q;
        end
        S_MIX_DLO: mix_wdata_d[15:0] = rx_word;
        S_MIX_DHI: begin
          mix_wdata_d[31:16] = rx_word;
          mix_we_d = 1'b1;
        end
`endif
        default: ;
      endcase
    if (rd_req) rd_wait_d = 1'b1;
    if (wr_req && !arb_free) wdrop_d = 1'b1;
  end

  always_comb begin
    cmd_active = state_q != S_IDLE;
    tx_word = tx_word_q;
`ifdef SPI_MEM_MIX_EN
    mix_addr = mix_addr_q;
    mix_wdata = mix_wdata_q;
    mix_we = mix_we_q;
    mix_re = mix_re_q;
`endif
  end
endmodule

// File: tb/tb_spi_mem_cmd_decoder.sv
// tb_spi_mem_cmd_decoder: directed frames against a queue-based model of expected SDRAM traffic
module tb_spi_mem_cmd_decoder;
  localparam int GAP = 10;
  typedef struct {logic [31:0] a; logic [15:0] d;} wr_t;
  typedef struct {int due; logic [15:0] d;} rsp_t;

  logic clk = 0, rst = 1, rx_valid = 0, busy = 0, rd_ready = 0;
  logic [15:0] rx_word = 0, rd_data = 0, tx_word, wr_data;
  logic [31:0] wr_addr, rd_addr;
  logic wr_enable, rd_enable, cmd_active;

  int tests = 0, fails = 0, wr_seen = 0, lat = 2, n0;
  wr_t exp_wr[$];
  logic [31:0] exp_rd[$];
  rsp_t rq[$];
  logic [15:0] mem [logic [31:0]];

  spi_mem_cmd_decoder dut (
    .clk(clk), .rst(rst), .rx_word(rx_word), .rx_valid(rx_valid), .tx_word(tx_word),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data), .rd_ready(rd_ready),
    .busy(busy), .cmd_active(cmd_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic frame(input logic [15:0] w, input bit chk = 0, input logic [15:0] exp = 0,
                       input string nm = "tx_word");
    @(negedge clk);
    if (chk) check(nm, tx_word, exp);
    @(posedge clk); #1;
    rx_word = w;
    rx_valid = 1;
    @(posedge clk); #1;
    rx_valid = 0;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_wr.push_back(e);
  endtask

  // SDRAM responder: stores writes, answers reads in order after lat cycles
  initial begin : responder
    int cyc = 0;
    rsp_t r;
    forever begin
      @(posedge clk); #2;
      cyc++;
      rd_ready = 0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        rd_ready = 1;
        rd_data = rq[0].d;
        void'(rq.pop_front());
      end
      if (wr_enable) mem[wr_addr] = wr_data;
      if (rd_enable) begin
        r.due = cyc + lat;
        r.d = mem.exists(rd_addr) ? mem[rd_addr] : 16'h0;
        rq.push_back(r);
      end
    end
  end

  // Every request pulse must match the next expected transaction
  initial begin : compare
    wr_t e;
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      if (wr_enable) begin
        wr_seen++;
        if (exp_wr.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_extra: unexpected write addr=%0h data=%0h", wr_addr, wr_data);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", wr_addr, e.a);
          check("wr_data", wr_data, e.d);
        end
      end
      if (rd_enable) begin
        if (exp_rd.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_extra: unexpected read addr=%0h", rd_addr);
        end else begin
          ea = exp_rd.pop_front();
          check("rd_addr", rd_addr, ea);
        end
      end
      if (wr_enable && rd_enable) check("enable_overlap", {wr_enable, rd_enable}, 2'b10);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_tx_word", tx_word, 0);
    check("rst_cmd_active", cmd_active, 0);
    check("rst_wr_enable", wr_enable, 0);
    check("rst_rd_enable", rd_enable, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_data", wr_data, 0);

    frame(16'h8000);
    @(negedge clk) check("cmd_active_reg", cmd_active, 1);
    frame(16'h0000, 1, 16'hC45A, "id_read");
    @(negedge clk) check("cmd_active_idle", cmd_active, 0);

    push_wr(32'h0, 16'hABCD);
    frame(16'hC100); frame(16'h0000); frame(16'h0000); frame(16'hABCD);
    exp_rd.push_back(32'h0);
    frame(16'hC000); frame(16'h0000); frame(16'h0000); frame(16'h0000);
    frame(16'h8004);
    frame(16'h0000, 1, 16'hABCD, "reg4_read");

    for (int i = 0; i < 40; i++) push_wr(32'h20 + i, 16'h1234 + 16'(i));
    frame(16'hD100); frame(16'd40); frame(16'h0020); frame(16'h0000);
    for (int i = 0; i < 40; i++) frame(16'h1234 + 16'(i));
    for (int i = 0; i < 8; i++) exp_rd.push_back(32'h20 + i);
    frame(16'hD000); frame(16'd8); frame(16'h0020); frame(16'h0000); frame(16'h0000);
    for (int i = 0; i < 8; i++) frame(16'h0000, 1, 16'h1234 + 16'(i), "burst_rd");
    frame(16'h8001);
    frame(16'h0000, 1, 16'h0000, "status_clean");

    @(posedge clk); #1 busy = 1;
    n0 = wr_seen;
    push_wr(32'h100, 16'h5555);
    frame(16'hC100); frame(16'h0100); frame(16'h0000); frame(16'h5555);
    frame(16'hC100); frame(16'h0200); frame(16'h0000); frame(16'h6666);
    check("wr_held_busy", wr_seen - n0, 0);
    @(posedge clk); #1 busy = 0;
    @(negedge clk) check("wr_on_busy_fall", wr_enable, 1);
    repeat (5) @(posedge clk);
    check("wr_once", wr_seen - n0, 1);
    frame(16'h8001);
    frame(16'h0000, 1, 16'h0002, "status_wdrop");
    frame(16'h8001);
    frame(16'h0000, 1, 16'h0000, "status_wdrop_cleared");

    lat = 25;
    exp_rd.push_back(32'h20);
    exp_rd.push_back(32'h21);
    frame(16'hD000); frame(16'd2); frame(16'h0020); frame(16'h0000);
    frame(16'h0000); frame(16'h0000); frame(16'h0000);
    repeat (60) @(posedge clk);
    lat = 2;
    frame(16'h8001);
    frame(16'h0000, 1, 16'h0001, "status_underrun");
    frame(16'h8001);
    frame(16'h0000, 1, 16'h0000, "status_underrun_cleared");

    push_wr(32'h300, 16'hAAAA);
    push_wr(32'h301, 16'hBBBB);
    frame(16'hD100); frame(16'd5); frame(16'h0300); frame(16'h0000);
    frame(16'hAAAA); frame(16'hBBBB);
    @(posedge clk); #1 busy = 1;
    frame(16'hCCCC);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 busy = 0;
    @(posedge clk); #1 rst = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rst_mid_idle", cmd_active, 0);
    check("rst_mid_tx", tx_word, 0);
    frame(16'h8000);
    frame(16'h0000, 1, 16'hC45A, "id_after_rst");

    push_wr(32'hFFFF_FFFF, 16'h0A0A);
    push_wr(32'h0000_0000, 16'h0B0B);
    frame(16'hD100); frame(16'd2); frame(16'hFFFF); frame(16'hFFFF);
    frame(16'h0A0A); frame(16'h0B0B);
    repeat (5) @(posedge clk);

    check("wr_left", exp_wr.size(), 0);
    check("rd_left", exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_mem_cmd_decoder.md
Name: spi_mem_cmd_decoder

Overview:
- Command layer between the SPI2 word-level slave PHY and the SDRAM host port. The PHY delivers one 16-bit word per CS frame and shifts out `tx_word` during that frame.
- The block parses command words into register reads, single memory read/write and burst memory read/write. It drives `sdram_controller` wr/rd request pins and captures read data for return over SPI.

Parameters:
- ID_VALUE, 16'hC45A, value returned by register 0.
- ADDR_W, 32, SDRAM word-address width.
- DATA_W, 16, SPI word and SDRAM data width; fixed at 16.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx_word  in  16  word received in the last completed SPI frame.
- rx_valid  in  1  one-cycle strobe: rx_word valid, frame complete.
- tx_word  out  16  word the PHY shifts out in the next frame; sampled by the PHY on CS falling edge.
- wr_addr  out  ADDR_W  SDRAM write address.
- wr_data  out  16  SDRAM write data.
- wr_enable  out  1  one-cycle write request.
- rd_addr  out  ADDR_W  SDRAM read address.
- rd_enable  out  1  one-cycle read request.
- rd_data  in  16  SDRAM read data.
- rd_ready  in  1  one-cycle strobe: rd_data valid.
- busy  in  1  SDRAM controller cannot accept a request.
- cmd_active  out  1  decoder not in IDLE.

Behaviour:
- Reset: state=IDLE, tx_word=0, wr_enable=rd_enable=0, wr_addr=rd_addr=0, wr_data=0, cmd_active=0, internal addr/len/rdbuf/status=0.
- Interface decision: one clock; reset is synchronous and active-high.
- All state advances only on rx_valid, except memory-wait handling. rx_word is sampled on the same cycle as rx_valid.
- Command words, decoded in IDLE:
  - 0x80aa: register read. tx_word <= reg[aa] within 1 cycle. Next frame is a don't-care and returns to IDLE.
  - 0xC000: single read. ADDR_LO, then ADDR_HI, then one dummy frame. At the ADDR_HI rx_valid the read is issued; result goes to reg4.
  - 0xC100: single write. ADDR_LO, ADDR_HI, DATA. Write is issued on the DATA rx_valid.
  - 0xD000 (read) / 0xD100 (write): burst. Bit 8 = 1 means write. Sequence: LEN, ADDR_LO, ADDR_HI.
    - Write burst: LEN data frames. Each data frame issues a write at addr, then addr++.
    - Read burst: read of addr issued at the ADDR_HI rx_valid, then one dummy frame. Each of LEN data frames returns the prefetched word in tx_word; at each data rx_valid the read of addr+1 is issued.
  - Any other word: ignored, stay IDLE.
- Registers:
  - 0 = ID_VALUE.
  - 1 = status: bit0 underrun (sticky), bit1 write-dropped (sticky), bit2 busy, bits[7:4] state. Reading reg1 clears the sticky bits.
  - 2/3 = addr lo/hi.
  - 4 = last read data.
  - 5 = mix hi (with MIX feature), else 0.
  - All other addresses = 0.
- Request handshake: a request is held pending while busy=1. It pulses wr_enable or rd_enable for exactly one cycle on the first cycle busy=0. Only one outstanding request exists at a time.
- New request while pending:
  - Write: dropped; set status bit1.
  - Read burst: if the rd_ready for the previous prefetch has not arrived by the next rx_valid, set status bit0. The stale tx_word is shifted out and the sequence continues.
- rd_ready: rdbuf <= rd_data; tx_word <= rd_data in burst-read, else reg4 <= rd_data.
- Address arithmetic: ADDR_W-bit, increment wraps 0xFFFFFFFF -> 0.
- LEN: 16-bit word count. LEN = 0 completes at the ADDR_HI frame; a read burst still consumes the dummy frame, with no prefetch issued.
- Reset mid-burst: abort immediately. Pending requests are discarded; no enable pulse is emitted after reset.

Optional Feature:
- Macro SPI_MEM_MIX_EN.
- Defined: commands 0x9100 (mix write: ADDR, DATA_LO, DATA_HI) and 0x9000 (mix read: ADDR, dummy) are supported. They drive an extra mix_addr[7:0] / mix_wdata[31:0] / mix_we / mix_re / mix_rdata[31:0] port group, with 1-cycle strobes. Mix read data lands in reg4 (lo) and reg5 (hi).
- Undefined: 0x90xx/0x91xx are treated as unknown and ignored, the mix ports are absent, and reg5 reads 0.

Decomposition:
- Package spi_mem_pkg holds:
  - command opcode constants (CMD_REG_RD=8'h80, CMD_MEM=8'hC0, CMD_BURST=8'hD0, CMD_MIX=8'h90);
  - register index constants;
  - the state enum typedef;
  - status bit positions.
- Sub-module spi_mem_req_arb: one-deep pending-request holder that turns requests plus busy into one-cycle wr_enable/rd_enable pulses.

Test Plan:
- Reset, then 0x8000 + dummy -> tx_word=0xC45A in the second frame; cmd_active returns to 0.
- 0xC100, 0x0000, 0x0000, 0xABCD, then 0xC000, 0, 0, dummy, 0x8004, dummy -> one wr_enable at addr 0 with data 0xABCD; second-frame tx_word=0xABCD.
- Write burst 0xD100, len=40, addr=0x20, 40x 0x1234 -> 40 wr_enable pulses at addr 0x20..0x47. Read burst 0xD000, len=8, addr=0x20 -> 8 frames return 0x1234 with no underrun.
- busy held high 500 ns around a single write -> wr_enable emitted exactly once, on the first cycle busy falls. A second write inside the window sets status bit1.
- Read burst with rd_ready delayed past the next rx_valid -> status bit0=1; a read of reg1 returns bit0=1, then a reread returns 0.
- Assert rst during burst data frame 3 -> no further enables, state IDLE. Next 0x8000 returns 0xC45A. Address wrap: burst at 0xFFFFFFFF with len 2 -> writes at 0xFFFFFFFF and 0x0.
